// File: rtl/lfsr_gen_if.sv
//------------------------------------------------------------------------------
// lfsr_gen_if
// Bundles the control and pattern signals between the test controller
// (master) and the LFSR pattern generator (slave).
//   load, seed_in      : seed load request and value
//   en                 : single-step request
//   start, burst_len   : burst request and number of steps
//   state, bit_out     : current LFSR register and its LSB
//   busy, done         : burst in progress / burst completion pulse
//   wrap, period       : return-to-seed pulse and measured cycle length
//   lockup             : all-zero lock-up indication
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface lfsr_gen_if #(
   parameter int unsigned WIDTH = 4
);
   logic              load;
   logic [WIDTH-1:0]  seed_in;
   logic              en;
   logic              start;
   logic [15:0]       burst_len;
   logic [WIDTH-1:0]  state;
   logic              bit_out;
   logic              busy;
   logic              done;
   logic              wrap;
   logic [WIDTH-1:0]  period;
   logic              lockup;

   modport master (
      output load, seed_in, en, start, burst_len,
      input  state, bit_out, busy, done, wrap, period, lockup
   );

   modport slave (
      input  load, seed_in, en, start, burst_len,
      output state, bit_out, busy, done, wrap, period, lockup
   );
endinterface

// File: rtl/lfsr_gen.sv
//------------------------------------------------------------------------------
// lfsr_gen
// Parametrised Fibonacci LFSR for memory-test / BIST pattern generation.
// Supports runtime seed load, single steps, bursts with a start/done
// handshake, wrap detection with period measurement and lock-up handling.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : lfsr_gen_if.slave (load/seed_in/en/start/burst_len in,
//          state/bit_out/busy/done/wrap/period/lockup out)
//
// Optional feature macro: LFSR_LOCKUP_RECOVER_EN
//   defined   : a zero seed is replaced by SEED_DEFAULT and lockup pulses
//   undefined : zero is loaded as given; lockup is high while state is 0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module lfsr_gen #(
   parameter int unsigned      WIDTH        = 4,
   parameter logic [WIDTH-1:0] TAPS         = WIDTH'(4'b0011),
   parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1'b1)
) (
   input  logic        clk,
   input  logic        rst,
   lfsr_gen_if.slave   bus
);

   localparam logic [0:0]       IDLE  = 1'b0;
   localparam logic [0:0]       BURST = 1'b1;
   localparam logic [WIDTH-1:0] ZERO  = '0;
   localparam logic [WIDTH-1:0] ONE   = WIDTH'(1'b1);

   // Feedback bit: parity of the tapped state bits.
   function automatic logic feedback(input logic [WIDTH-1:0] s);
      return ^(s & TAPS);
   endfunction

   // One Fibonacci shift: feedback enters at the MSB, LSB drops out.
   function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
      return {feedback(s), s[WIDTH-1:1]};
   endfunction

   logic [WIDTH-1:0] state_r, state_nxt_s;
   logic [WIDTH-1:0] ref_r, ref_nxt_s;
   logic [WIDTH-1:0] cnt_r, cnt_nxt_s;
   logic [WIDTH-1:0] period_r, period_nxt_s;
   logic [0:0]       fsm_r, fsm_nxt_s;
   logic [15:0]      rem_r, rem_nxt_s;
   logic             busy_r;
   logic             done_r, done_nxt_s;
   logic             wrap_r, wrap_nxt_s;
   logic             lockup_r, lockup_nxt_s;
   logic             do_step_s;
   logic [WIDTH-1:0] stepped_s;
   logic [WIDTH-1:0] load_val_s;
   logic             zero_seed_s;

   // Next-state logic: load beats burst stepping, which beats start, then en.
   always_comb begin
      state_nxt_s  = state_r;
      ref_nxt_s    = ref_r;
      cnt_nxt_s    = cnt_r;
      period_nxt_s = period_r;
      fsm_nxt_s    = fsm_r;
      rem_nxt_s    = rem_r;
      done_nxt_s   = 1'b0;
      wrap_nxt_s   = 1'b0;
      do_step_s    = 1'b0;
      stepped_s    = lfsr_step(state_r);
      zero_seed_s  = (bus.seed_in == ZERO);
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (zero_seed_s) begin
         load_val_s = SEED_DEFAULT;
      end else begin
         load_val_s = bus.seed_in;
      end
`else
      load_val_s = bus.seed_in;
`endif

      if (bus.load) begin
         // Load aborts any burst silently and restarts period measurement.
         state_nxt_s = load_val_s;
         ref_nxt_s   = load_val_s;
         cnt_nxt_s   = ZERO;
         fsm_nxt_s   = IDLE;
         rem_nxt_s   = 16'd0;
      end else begin
         case (fsm_r)
            IDLE: begin
               if (bus.start) begin
                  if (bus.burst_len != 16'd0) begin
                     fsm_nxt_s = BURST;
                     rem_nxt_s = bus.burst_len;
                  end else begin
                     done_nxt_s = 1'b1;
                  end
               end else if (bus.en) begin
                  do_step_s = 1'b1;
               end else begin
                  do_step_s = 1'b0;
               end
            end
            BURST: begin
               do_step_s = 1'b1;
               rem_nxt_s = rem_r - 16'd1;
               if (rem_r == 16'd1) begin
                  fsm_nxt_s  = IDLE;
                  done_nxt_s = 1'b1;
               end else begin
                  fsm_nxt_s  = BURST;
               end
            end
            default: begin
               fsm_nxt_s = IDLE;
               rem_nxt_s = 16'd0;
            end
         endcase

         if (do_step_s) begin
            state_nxt_s = stepped_s;
            // Wrap is judged on the value being stepped into, so the pulse
            // lines up with the state update that returns to the seed.
            if (stepped_s == ref_r) begin
               wrap_nxt_s   = 1'b1;
               period_nxt_s = cnt_r + ONE;
               cnt_nxt_s    = ZERO;
            end else begin
               cnt_nxt_s    = cnt_r + ONE;
            end
         end else begin
            state_nxt_s = state_r;
         end
      end

`ifdef LFSR_LOCKUP_RECOVER_EN
      lockup_nxt_s = bus.load & zero_seed_s;
`else
      lockup_nxt_s = (state_nxt_s == ZERO);
`endif
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= SEED_DEFAULT;
         ref_r    <= SEED_DEFAULT;
         cnt_r    <= ZERO;
         period_r <= ZERO;
         fsm_r    <= IDLE;
         rem_r    <= 16'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         wrap_r   <= 1'b0;
         lockup_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         ref_r    <= ref_nxt_s;
         cnt_r    <= cnt_nxt_s;
         period_r <= period_nxt_s;
         fsm_r    <= fsm_nxt_s;
         rem_r    <= rem_nxt_s;
         busy_r   <= (fsm_nxt_s == BURST);
         done_r   <= done_nxt_s;
         wrap_r   <= wrap_nxt_s;
         lockup_r <= lockup_nxt_s;
      end
   end

   assign bus.state   = state_r;
   assign bus.bit_out = state_r[0];
   assign bus.busy    = busy_r;
   assign bus.done    = done_r;
   assign bus.wrap    = wrap_r;
   assign bus.period  = period_r;
   assign bus.lockup  = lockup_r;

endmodule

// File: tb/tb_lfsr_gen.sv
//------------------------------------------------------------------------------
// tb_lfsr_gen
// Self-checking bench for lfsr_gen: a vector table for the basic step, burst
// and zero-length burst behaviour, hand-written sequences for burst abort,
// zero seed, mid-burst reset and an 8-bit full period, then random stimulus
// compared against a behavioural model.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lfsr_gen;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lfsr_gen_if #(.WIDTH(4)) bus4 ();
   lfsr_gen_if #(.WIDTH(8)) bus8 ();

   lfsr_gen #(.WIDTH(4), .TAPS(4'b0011), .SEED_DEFAULT(4'h1)) u_dut4 (
      .clk(clk), .rst(rst), .bus(bus4)
   );

   lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .SEED_DEFAULT(8'h01)) u_dut8 (
      .clk(clk), .rst(rst), .bus(bus8)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        ld;
      logic [3:0]  sd;
      logic        en;
      logic        st;
      logic [15:0] bl;
      logic [3:0]  es;
      logic        eb;
      logic        ed;
      logic        ew;
      logic [3:0]  ep;
   } vec_t;

   vec_t vecs[$];

   // Behavioural model state (plain integers).
   int  m_state, m_ref, m_cnt, m_period, m_left;
   bit  m_done, m_wrap, m_lock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [3:0] es, input logic eb,
                          input logic ed, input logic ew, input logic [3:0] ep);
      check({tag, "_state"},  32'(bus4.state),   32'(es));
      check({tag, "_bitout"}, 32'(bus4.bit_out), 32'(es[0]));
      check({tag, "_busy"},   32'(bus4.busy),    32'(eb));
      check({tag, "_done"},   32'(bus4.done),    32'(ed));
      check({tag, "_wrap"},   32'(bus4.wrap),    32'(ew));
      check({tag, "_period"}, 32'(bus4.period),  32'(ep));
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 ns later.
   task automatic cyc(input logic ld, input logic [3:0] sd, input logic e,
                      input logic st, input logic [15:0] bl);
      bus4.load      = ld;
      bus4.seed_in   = sd;
      bus4.en        = e;
      bus4.start     = st;
      bus4.burst_len = bl;
      @(posedge clk);
      #1;
   endtask

   function automatic int model_next(input int s, input int taps, input int w);
      int ones;
      int masked;
      ones   = 0;
      masked = s & taps;
      for (int b = 0; b < w; b++) ones += (masked >> b) & 1;
      return (s >> 1) | ((ones % 2) << (w - 1));
   endfunction

   task automatic model_advance();
      int n;
      n = model_next(m_state, 3, 4);
      m_cnt = (m_cnt + 1) % 16;
      if (n == m_ref) begin
         m_wrap   = 1'b1;
         m_period = m_cnt;
         m_cnt    = 0;
      end
      m_state = n;
   endtask

   task automatic model_cycle(input bit ld, input int sd, input bit e, input bit st, input int bl);
      int v;
      m_done = 1'b0;
      m_wrap = 1'b0;
      m_lock = 1'b0;
      if (ld) begin
         v = sd;
`ifdef LFSR_LOCKUP_RECOVER_EN
         if (v == 0) begin
            v      = 1;
            m_lock = 1'b1;
         end
`endif
         m_state = v;
         m_ref   = v;
         m_cnt   = 0;
         m_left  = 0;
      end else if (m_left > 0) begin
         model_advance();
         m_left--;
         if (m_left == 0) m_done = 1'b1;
      end else if (st) begin
         if (bl > 0) m_left = bl;
         else        m_done = 1'b1;
      end else if (e) begin
         model_advance();
      end
`ifndef LFSR_LOCKUP_RECOVER_EN
      m_lock = (m_state == 0);
`endif
   endtask

   initial begin
      logic [3:0] seq1 [15];
      int         wrap_at;
      bit         rl, re, rs;
      int         rsd, rbl;

      seq1 = '{4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6, 4'hB, 4'h5,
               4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3, 4'h1};

      // en held high: full 15-state cycle, wrap on the return to 1.
      for (int i = 0; i < 15; i++)
         vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 16'd0, seq1[i], 1'b0, 1'b0,
                          (i == 14), (i == 14) ? 4'd15 : 4'd0});
      // Load 9 then a burst of 3 with en/start noise during the burst.
      vecs.push_back('{1'b1, 4'h9, 1'b0, 1'b0, 16'd0, 4'h9, 1'b0, 1'b0, 1'b0, 4'd15});
      vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 16'd3, 4'h9, 1'b1, 1'b0, 1'b0, 4'd15});
      vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 16'd0, 4'hC, 1'b1, 1'b0, 1'b0, 4'd15});
      vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b1, 16'd7, 4'h6, 1'b1, 1'b0, 1'b0, 4'd15});
      vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b0, 16'd0, 4'hB, 1'b0, 1'b1, 1'b0, 4'd15});
      vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 16'd0, 4'hB, 1'b0, 1'b0, 1'b0, 4'd15});
      // Zero-length burst: done next cycle, no step, never busy.
      vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b1, 16'd0, 4'hB, 1'b0, 1'b1, 1'b0, 4'd15});
      vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 16'd0, 4'hB, 1'b0, 1'b0, 1'b0, 4'd15});
      // start and en together: start wins, burst of 2.
      vecs.push_back('{1'b0, 4'h0, 1'b1, 1'b1, 16'd2, 4'hB, 1'b1, 1'b0, 1'b0, 4'd15});
      vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 16'd0, 4'h5, 1'b1, 1'b0, 1'b0, 4'd15});
      vecs.push_back('{1'b0, 4'h0, 1'b0, 1'b0, 16'd0, 4'hA, 1'b0, 1'b1, 1'b0, 4'd15});

      bus4.load = 1'b0; bus4.seed_in = 4'h0; bus4.en = 1'b0;
      bus4.start = 1'b0; bus4.burst_len = 16'd0;
      bus8.load = 1'b0; bus8.seed_in = 8'h00; bus8.en = 1'b0;
      bus8.start = 1'b0; bus8.burst_len = 16'd0;

      // Reset state.
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 4'h1, 1'b0, 1'b0, 1'b0, 4'd0);
      check("reset_lockup", 32'(bus4.lockup), 32'd0);
      rst = 1'b0;

      // Vector table.
      foreach (vecs[k]) begin
         cyc(vecs[k].ld, vecs[k].sd, vecs[k].en, vecs[k].st, vecs[k].bl);
         chk_all($sformatf("vec%0d", k), vecs[k].es, vecs[k].eb, vecs[k].ed,
                 vecs[k].ew, vecs[k].ep);
      end

      // Burst of 10 aborted by a load of 5 in its 4th busy cycle.
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 16'd10);
      chk_all("abort_c1", 4'hA, 1'b1, 1'b0, 1'b0, 4'd15);
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
      chk_all("abort_c2", 4'hD, 1'b1, 1'b0, 1'b0, 4'd15);
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
      chk_all("abort_c3", 4'hE, 1'b1, 1'b0, 1'b0, 4'd15);
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
      chk_all("abort_c4", 4'hF, 1'b1, 1'b0, 1'b0, 4'd15);
      cyc(1'b1, 4'h5, 1'b0, 1'b0, 16'd0);
      chk_all("abort_load", 4'h5, 1'b0, 1'b0, 1'b0, 4'd15);
      for (int i = 1; i <= 15; i++) begin
         cyc(1'b0, 4'h0, 1'b1, 1'b0, 16'd0);
         check($sformatf("rewrap_wrap%0d", i), 32'(bus4.wrap), 32'(i == 15));
         check($sformatf("rewrap_done%0d", i), 32'(bus4.done), 32'd0);
      end
      check("rewrap_state", 32'(bus4.state), 32'h5);
      check("rewrap_period", 32'(bus4.period), 32'd15);

      // Zero seed load.
      cyc(1'b1, 4'h0, 1'b0, 1'b0, 16'd0);
`ifdef LFSR_LOCKUP_RECOVER_EN
      check("zero_state", 32'(bus4.state), 32'h1);
      check("zero_lockup", 32'(bus4.lockup), 32'd1);
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
      check("zero_lockup_end", 32'(bus4.lockup), 32'd0);
      cyc(1'b0, 4'h0, 1'b1, 1'b0, 16'd0);
      chk_all("zero_step", 4'h8, 1'b0, 1'b0, 1'b0, 4'd15);
      check("zero_step_lockup", 32'(bus4.lockup), 32'd0);
`else
      chk_all("zero_load", 4'h0, 1'b0, 1'b0, 1'b0, 4'd15);
      check("zero_lockup", 32'(bus4.lockup), 32'd1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 4'h0, 1'b1, 1'b0, 16'd0);
         chk_all($sformatf("stuck%0d", i), 4'h0, 1'b0, 1'b0, 1'b1, 4'd1);
         check($sformatf("stuck_lockup%0d", i), 32'(bus4.lockup), 32'd1);
      end
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
      check("stuck_idle_wrap", 32'(bus4.wrap), 32'd0);
      check("stuck_idle_lockup", 32'(bus4.lockup), 32'd1);
`endif

      // Reset in the middle of a burst.
      cyc(1'b1, 4'h9, 1'b0, 1'b0, 16'd0);
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 16'd10);
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
      check("midburst_busy", 32'(bus4.busy), 32'd1);
      rst = 1'b1;
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
      chk_all("rst_mid", 4'h1, 1'b0, 1'b0, 1'b0, 4'd0);
      check("rst_mid_lockup", 32'(bus4.lockup), 32'd0);
      rst = 1'b0;
      cyc(1'b0, 4'h0, 1'b0, 1'b0, 16'd0);
      chk_all("rst_after", 4'h1, 1'b0, 1'b0, 1'b0, 4'd0);

      // 8-bit full period with taps 0x1D.
      wrap_at = 0;
      bus8.en = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         @(posedge clk);
         #1;
         if (bus8.wrap && wrap_at == 0) wrap_at = i;
         if (wrap_at != 0) break;
      end
      bus8.en = 1'b0;
      if (wrap_at == 0) begin
         check("w8_timeout", 32'd0, 32'd1);
      end else begin
         check("w8_steps", 32'(wrap_at), 32'd255);
         check("w8_period", 32'(bus8.period), 32'd255);
         check("w8_state", 32'(bus8.state), 32'h01);
      end

      // Random stimulus against the model; DUT is idle at state 1 after reset.
      m_state = 1; m_ref = 1; m_cnt = 0; m_period = 0; m_left = 0;
      m_done = 1'b0; m_wrap = 1'b0; m_lock = 1'b0;
      for (int i = 0; i < 600; i++) begin
         rl  = ($urandom_range(15) == 0);
         rsd = $urandom_range(15);
         re  = ($urandom_range(1) == 1);
         rs  = ($urandom_range(7) == 0);
         rbl = $urandom_range(6);
         cyc(rl, 4'(rsd), re, rs, 16'(rbl));
         model_cycle(rl, rsd, re, rs, rbl);
         check($sformatf("rnd%0d_state", i),  32'(bus4.state),  32'(m_state));
         check($sformatf("rnd%0d_busy", i),   32'(bus4.busy),   32'(m_left > 0));
         check($sformatf("rnd%0d_done", i),   32'(bus4.done),   32'(m_done));
         check($sformatf("rnd%0d_wrap", i),   32'(bus4.wrap),   32'(m_wrap));
         check($sformatf("rnd%0d_period", i), 32'(bus4.period), 32'(m_period));
         check($sformatf("rnd%0d_lockup", i), 32'(bus4.lockup), 32'(m_lock));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
